// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU and memory producer handshakes plus the
// registered register-file write port. The arbiter uses the slave modport,
// the producers / register-file side use the master modport.
interface wb_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32
);
    localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS);

    logic                     alu_valid_in;
    logic                     alu_ready_out;
    logic [ADDRESS_WIDTH-1:0] alu_rd_in;
    logic [DATA_WIDTH-1:0]    alu_data_in;

    logic                     mem_valid_in;
    logic                     mem_ready_out;
    logic [ADDRESS_WIDTH-1:0] mem_rd_in;
    logic [DATA_WIDTH-1:0]    mem_data_in;

    logic                     wr_en_out;
    logic [ADDRESS_WIDTH-1:0] rd_out;
    logic [DATA_WIDTH-1:0]    rd_data_out;

    modport slave (
        input  alu_valid_in,
        input  alu_rd_in,
        input  alu_data_in,
        input  mem_valid_in,
        input  mem_rd_in,
        input  mem_data_in,
        output alu_ready_out,
        output mem_ready_out,
        output wr_en_out,
        output rd_out,
        output rd_data_out
    );

    modport master (
        output alu_valid_in,
        output alu_rd_in,
        output alu_data_in,
        output mem_valid_in,
        output mem_rd_in,
        output mem_data_in,
        input  alu_ready_out,
        input  mem_ready_out,
        input  wr_en_out,
        input  rd_out,
        input  rd_data_out
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of the ALU / memory results per cycle and
// drives a registered write into the register file. The ALU has fixed
// priority. Define WB_FAIRNESS_EN to compile in the starvation guard that
// forces the memory result through after MAX_STALL refusals.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_NORMAL | ALU always ready, memory ready only when the ALU is idle
// ST_FORCE  | ALU held off, memory ready (starvation bound reached)
module wb_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int MAX_STALL     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS);
    localparam logic [ADDRESS_WIDTH-1:0] RD_ZERO = '0;

    if (MAX_STALL < 1) begin : g_max_stall_check
        $error("wb_arbiter: MAX_STALL must be at least 1");
    end

    logic                     alu_ready;
    logic                     mem_ready;
    logic                     alu_xfer;
    logic                     mem_xfer;
    logic [ADDRESS_WIDTH-1:0] win_rd;
    logic [DATA_WIDTH-1:0]    win_data;

    logic                     wr_en_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0]    rd_data_q;

`ifdef WB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] stall_d;

    // Arbitration state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    // Ready generation, counter update and state transitions.
    // FORCE is entered on the same edge the counter reaches MAX_STALL, so the
    // memory result is accepted on the (MAX_STALL+1)th edge of continuous
    // ALU traffic. Leaving FORCE always clears the counter: either the memory
    // result transferred, or its valid dropped and the force is abandoned.
    always_comb begin
        alu_ready = 1'b1;
        mem_ready = !bus.alu_valid_in;
        state_d   = state_q;
        stall_d   = stall_q;
        case (state_q)
            ST_NORMAL: begin
                if (bus.mem_valid_in && !bus.alu_valid_in) begin
                    stall_d = '0;
                end else if (bus.mem_valid_in && (stall_q != STALL_MAX)) begin
                    stall_d = stall_q + 1'b1;
                end
                if (stall_d == STALL_MAX) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                alu_ready = 1'b0;
                mem_ready = 1'b1;
                state_d   = ST_NORMAL;
                stall_d   = '0;
            end
            default: begin
                state_d = ST_NORMAL;
                stall_d = '0;
            end
        endcase
    end
`else
    // Strict ALU priority; the memory path may wait indefinitely.
    always_comb begin
        alu_ready = 1'b1;
        mem_ready = !bus.alu_valid_in;
    end
`endif

    assign alu_xfer = bus.alu_valid_in && alu_ready;
    assign mem_xfer = bus.mem_valid_in && mem_ready;

    // Winning source mux; readies guarantee at most one transfer per cycle.
    always_comb begin
        win_rd   = bus.mem_rd_in;
        win_data = bus.mem_data_in;
        if (alu_xfer) begin
            win_rd   = bus.alu_rd_in;
            win_data = bus.alu_data_in;
        end
    end

    // Registered write port. A transfer to x0 is consumed but leaves the
    // address/data registers untouched so the port shows no activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            rd_q      <= '0;
            rd_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if ((alu_xfer || mem_xfer) && (win_rd != RD_ZERO)) begin
                wr_en_q   <= 1'b1;
                rd_q      <= win_rd;
                rd_data_q <= win_data;
            end
        end
    end

    assign bus.alu_ready_out = alu_ready;
    assign bus.mem_ready_out = mem_ready;
    assign bus.wr_en_out     = wr_en_q;
    assign bus.rd_out        = rd_q;
    assign bus.rd_data_out   = rd_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: stimulus pushes expected register-file
// writes (with the cycle they must appear) into a queue; a monitor pops and
// compares whenever wr_en_out is high. Ready outputs are checked directly.
module tb_wb_arbiter;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int MS = 4;
`ifdef WB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) bus ();

    wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .MAX_STALL(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        @(negedge clk);
        bus.alu_valid_in = av;
        bus.alu_rd_in    = ard;
        bus.alu_data_in  = ad;
        bus.mem_valid_in = mv;
        bus.mem_rd_in    = mrd;
        bus.mem_data_in  = md;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.cyc  = cyc + 1;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed write must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en_out) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                         bus.rd_out, bus.rd_data_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("wb_rd", 64'(bus.rd_out), 64'(mon_e.rd));
                check("wb_data", 64'(bus.rd_data_out), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ai;
        bit  mem_done;
        bit  force_now;

        bus.alu_valid_in = 1'b0;
        bus.alu_rd_in    = '0;
        bus.alu_data_in  = '0;
        bus.mem_valid_in = 1'b0;
        bus.mem_rd_in    = '0;
        bus.mem_data_in  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_en", 64'(bus.wr_en_out), 64'd0);
        check("rst_rd", 64'(bus.rd_out), 64'd0);
        check("rst_data", 64'(bus.rd_data_out), 64'd0);
        check("rst_alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        check("rst_mem_rdy", 64'(bus.mem_ready_out), 64'd1);
        rst_n = 1'b1;

        // ALU only
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check("alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        expect_wr(5'd5, 32'hDEADBEEF);
        idle();
        idle();
        check("alu_wr_en_drop", 64'(bus.wr_en_out), 64'd0);
        check("alu_rd_hold", 64'(bus.rd_out), 64'd5);
        check("alu_data_hold", 64'(bus.rd_data_out), 64'hDEADBEEF);

        // Collision: ALU first, memory one cycle later
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
        check("col_alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        check("col_mem_rdy", 64'(bus.mem_ready_out), 64'd0);
        expect_wr(5'd3, 32'h11);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h22);
        check("col_mem_rdy2", 64'(bus.mem_ready_out), 64'd1);
        expect_wr(5'd7, 32'h22);
        idle();

        // x0: consumed, no write, address/data hold
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
        check("x0_alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        idle();
        check("x0_wr_en", 64'(bus.wr_en_out), 64'd0);
        check("x0_rd_hold", 64'(bus.rd_out), 64'd7);
        check("x0_data_hold", 64'(bus.rd_data_out), 64'h22);

        // Back-to-back ALU results, then memory alone
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i), 32'(32'h100 + i), 1'b0, 5'd0, 32'h0);
            expect_wr(5'(i), 32'(32'h100 + i));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1234);
        check("mem_alone_rdy", 64'(bus.mem_ready_out), 64'd1);
        expect_wr(5'd12, 32'h1234);
        idle();

        // Reset asserted mid-cycle right after a write clears the port at once
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd6, 32'h66);
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(bus.wr_en_out), 64'd0);
        check("mid_rst_rd", 64'(bus.rd_out), 64'd0);
        check("mid_rst_data", 64'(bus.rd_data_out), 64'd0);
        check("mid_rst_alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        check("mid_rst_mem_rdy", 64'(bus.mem_ready_out), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Starvation: ALU valid every cycle, memory (9, 0xCAFE) waiting
        ai = 0;
        mem_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(16 + ai), 32'(32'hA000 + ai), !mem_done, 5'd9, 32'hCAFE);
            force_now = FAIR && (c == MS);
            check("stv_alu_rdy", 64'(bus.alu_ready_out), 64'(!force_now));
            check("stv_mem_rdy", 64'(bus.mem_ready_out), 64'(force_now));
            if (force_now) begin
                expect_wr(5'd9, 32'hCAFE);
                mem_done = 1'b1;
            end else begin
                expect_wr(5'(16 + ai), 32'(32'hA000 + ai));
                ai++;
            end
        end
        if (!mem_done) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'hCAFE);
            check("stv_mem_late_rdy", 64'(bus.mem_ready_out), 64'd1);
            expect_wr(5'd9, 32'hCAFE);
        end
        idle();

`ifdef WB_FAIRNESS_EN
        // Reset during FORCE aborts it; MS more refusals are needed again
        ai = 0;
        for (int c = 0; c < MS; c++) begin
            drive(1'b1, 5'(24 + ai), 32'(32'hB000 + ai), 1'b1, 5'd9, 32'hBEEF);
            check("rf_pre_mem_rdy", 64'(bus.mem_ready_out), 64'd0);
            expect_wr(5'(24 + ai), 32'(32'hB000 + ai));
            ai++;
        end
        drive(1'b1, 5'(24 + ai), 32'(32'hB000 + ai), 1'b1, 5'd9, 32'hBEEF);
        check("rf_force_alu_rdy", 64'(bus.alu_ready_out), 64'd0);
        check("rf_force_mem_rdy", 64'(bus.mem_ready_out), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rf_rst_wr_en", 64'(bus.wr_en_out), 64'd0);
        check("rf_rst_rd", 64'(bus.rd_out), 64'd0);
        check("rf_rst_alu_rdy", 64'(bus.alu_ready_out), 64'd1);
        check("rf_rst_mem_rdy", 64'(bus.mem_ready_out), 64'd0);
        #1 rst_n = 1'b1;
        expect_wr(5'(24 + ai), 32'(32'hB000 + ai));
        ai++;
        for (int c = 1; c < MS; c++) begin
            drive(1'b1, 5'(24 + ai), 32'(32'hB000 + ai), 1'b1, 5'd9, 32'hBEEF);
            check("rf_post_mem_rdy", 64'(bus.mem_ready_out), 64'd0);
            expect_wr(5'(24 + ai), 32'(32'hB000 + ai));
            ai++;
        end
        drive(1'b1, 5'(24 + ai), 32'(32'hB000 + ai), 1'b1, 5'd9, 32'hBEEF);
        check("rf_reforce_alu_rdy", 64'(bus.alu_ready_out), 64'd0);
        check("rf_reforce_mem_rdy", 64'(bus.mem_ready_out), 64'd1);
        expect_wr(5'd9, 32'hBEEF);
        idle();
`endif

        repeat (3) idle();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
